// File: rtl/desired_drive_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : desired_drive_ramp
//  Description : Pipelined eBike desired-drive calculator. Converts averaged
//                torque, cadence, incline and assist scale into a motor
//                target current. A slew-rate limiter on the output prevents
//                current steps that would jolt the rider.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                in_vld              - one-cycle input sample qualifier
//                avg_torque, cadence, not_pedaling, incline, scale - sample
//                out_vld             - one-cycle pulse, outputs updated
//                target_curr         - slew-limited target current
//                raw_curr, sat       - pre-ramp target and its saturation flag
//  Revision    : 1.0 - initial release
// ============================================================================
module desired_drive_ramp #(
    parameter int                TQ_W       = 12,
    parameter logic [TQ_W-1:0]   TORQUE_MIN = TQ_W'(12'h380),
    parameter int                INC_W      = 13,
    parameter int                CAD_W      = 5,
    parameter int                SCALE_W    = 3,
    parameter int                CUR_W      = 12,
    parameter int                SHIFT      = 15,
    parameter int                RAMP_UP    = 64,
    parameter int                RAMP_DN    = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_vld,
    input  logic [TQ_W-1:0]      avg_torque,
    input  logic [CAD_W-1:0]     cadence,
    input  logic                 not_pedaling,
    input  logic [INC_W-1:0]     incline,
    input  logic [SCALE_W-1:0]   scale,
    output logic                 out_vld,
    output logic [CUR_W-1:0]     target_curr,
    output logic [CUR_W-1:0]     raw_curr,
    output logic                 sat
);

    localparam int C_INC_LIM_W = 9;
    localparam int C_CADF_W    = CAD_W + 1;
    localparam int C_P1_W      = TQ_W + C_INC_LIM_W;
    localparam int C_P2_W      = C_CADF_W + SCALE_W;
    localparam int C_PROD_W    = C_P1_W + C_P2_W;
    // Product is widened so the overflow bits above the output window always exist.
    localparam int C_EXT_W     = (C_PROD_W > SHIFT + CUR_W) ? C_PROD_W : SHIFT + CUR_W + 1;
    localparam int C_RMP_W     = CUR_W + 1;

    localparam logic [C_RMP_W-1:0] C_RAMP_UP = C_RMP_W'(RAMP_UP);
    localparam logic [C_RMP_W-1:0] C_RAMP_DN = C_RMP_W'(RAMP_DN);

    // Stage 1
    logic                    s1_vld_q, s1_vld_d;
    logic [TQ_W-1:0]         tpos_q, tpos_d;
    logic [C_INC_LIM_W-1:0]  inc_lim_q, inc_lim_d;
    logic [C_CADF_W-1:0]     cad_f_q, cad_f_d;
    logic [SCALE_W-1:0]      scale_q, scale_d;
    logic                    np1_q, np1_d;
    // Stage 2
    logic                    s2_vld_q, s2_vld_d;
    logic [C_P1_W-1:0]       p1_q, p1_d;
    logic [C_P2_W-1:0]       p2_q, p2_d;
    logic                    np2_q, np2_d;
    // Stage 3
    logic                    s3_vld_q, s3_vld_d;
    logic [C_PROD_W-1:0]     prod_q, prod_d;
    logic                    np3_q, np3_d;
    // Stage 4
    logic                    s4_vld_q, s4_vld_d;
    logic [CUR_W-1:0]        raw4_q, raw4_d;
    logic                    sat4_q, sat4_d;
    logic                    np4_q, np4_d;
    // Output / ramp stage
    logic                    out_vld_q, out_vld_d;
    logic [CUR_W-1:0]        target_q, target_d;
    logic [CUR_W-1:0]        raw_curr_q, raw_curr_d;
    logic                    sat_q, sat_d;

    // Intermediate combinational values
    logic [INC_W:0]          inc_sum;
    logic [C_EXT_W-1:0]      prod_ext;
    logic [C_RMP_W-1:0]      tgt_ext, raw_ext, up_step, dn_step;

    always_comb begin
        // ---------------- Stage 1: factor ----------------
        s1_vld_d  = in_vld;
        tpos_d    = tpos_q;
        inc_lim_d = inc_lim_q;
        cad_f_d   = cad_f_q;
        scale_d   = scale_q;
        np1_d     = np1_q;
        // Clamping incline+256 to 0..511 subsumes the 10-bit signed
        // saturation: anything beyond +-512 lands outside 0..511 anyway.
        inc_sum   = {incline[INC_W-1], incline} + (INC_W+1)'(256);
        if (in_vld) begin
            tpos_d = (avg_torque > TORQUE_MIN) ? avg_torque - TORQUE_MIN : '0;
            if (inc_sum[INC_W]) begin
                inc_lim_d = '0;
            end else if (inc_sum > (INC_W+1)'(511)) begin
                inc_lim_d = '1;
            end else begin
                inc_lim_d = inc_sum[C_INC_LIM_W-1:0];
            end
            // cadence + 2^CAD_W is just a leading one on the cadence value.
            cad_f_d = (cadence > CAD_W'(1)) ? {1'b1, cadence} : '0;
            scale_d = scale;
            np1_d   = not_pedaling;
        end

        // ---------------- Stage 2: multiply ----------------
        s2_vld_d = s1_vld_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        np2_d    = np2_q;
        if (s1_vld_q) begin
            p1_d  = C_P1_W'(tpos_q) * C_P1_W'(inc_lim_q);
            p2_d  = C_P2_W'(cad_f_q) * C_P2_W'(scale_q);
            np2_d = np1_q;
        end

        // ---------------- Stage 3: full product ----------------
        s3_vld_d = s2_vld_q;
        prod_d   = prod_q;
        np3_d    = np3_q;
        if (s2_vld_q) begin
            prod_d = C_PROD_W'(p1_q) * C_PROD_W'(p2_q);
            np3_d  = np2_q;
        end

        // ---------------- Stage 4: shift / saturate ----------------
        s4_vld_d = s3_vld_q;
        raw4_d   = raw4_q;
        sat4_d   = sat4_q;
        np4_d    = np4_q;
        prod_ext = C_EXT_W'(prod_q);
        if (s3_vld_q) begin
            np4_d = np3_q;
            if (np3_q) begin
                raw4_d = '0;
                sat4_d = 1'b0;
            end else if (|prod_ext[C_EXT_W-1:SHIFT+CUR_W]) begin
                raw4_d = '1;
                sat4_d = 1'b1;
            end else begin
                raw4_d = prod_ext[SHIFT+CUR_W-1:SHIFT];
                sat4_d = 1'b0;
            end
        end

        // ---------------- Output: slew-rate limiter ----------------
        out_vld_d  = s4_vld_q;
        target_d   = target_q;
        raw_curr_d = raw_curr_q;
        sat_d      = sat_q;
        tgt_ext    = {1'b0, target_q};
        raw_ext    = {1'b0, raw4_q};
        up_step    = tgt_ext + C_RAMP_UP;
        dn_step    = (tgt_ext >= C_RAMP_DN) ? tgt_ext - C_RAMP_DN : '0;
        if (s4_vld_q) begin
            raw_curr_d = raw4_q;
            sat_d      = sat4_q;
            if (np4_q) begin
                target_d = '0;
            end else if (raw_ext > tgt_ext) begin
                target_d = (up_step > raw_ext) ? raw4_q : up_step[CUR_W-1:0];
            end else if (raw_ext < tgt_ext) begin
                target_d = (dn_step < raw_ext) ? raw4_q : dn_step[CUR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            tpos_q     <= '0;
            inc_lim_q  <= '0;
            cad_f_q    <= '0;
            scale_q    <= '0;
            np1_q      <= 1'b0;
            s2_vld_q   <= 1'b0;
            p1_q       <= '0;
            p2_q       <= '0;
            np2_q      <= 1'b0;
            s3_vld_q   <= 1'b0;
            prod_q     <= '0;
            np3_q      <= 1'b0;
            s4_vld_q   <= 1'b0;
            raw4_q     <= '0;
            sat4_q     <= 1'b0;
            np4_q      <= 1'b0;
            out_vld_q  <= 1'b0;
            target_q   <= '0;
            raw_curr_q <= '0;
            sat_q      <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            tpos_q     <= tpos_d;
            inc_lim_q  <= inc_lim_d;
            cad_f_q    <= cad_f_d;
            scale_q    <= scale_d;
            np1_q      <= np1_d;
            s2_vld_q   <= s2_vld_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            np2_q      <= np2_d;
            s3_vld_q   <= s3_vld_d;
            prod_q     <= prod_d;
            np3_q      <= np3_d;
            s4_vld_q   <= s4_vld_d;
            raw4_q     <= raw4_d;
            sat4_q     <= sat4_d;
            np4_q      <= np4_d;
            out_vld_q  <= out_vld_d;
            target_q   <= target_d;
            raw_curr_q <= raw_curr_d;
            sat_q      <= sat_d;
        end
    end

    assign out_vld     = out_vld_q;
    assign target_curr = target_q;
    assign raw_curr    = raw_curr_q;
    assign sat         = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_desired_drive_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_desired_drive_ramp
//  Description : Scoreboard bench for desired_drive_ramp. Stimulus pushes the
//                hand-computed expected output of each sample; a monitor pops
//                and compares on every out_vld, including output timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_desired_drive_ramp;

    logic        clk;
    logic        rst_n;
    logic        in_vld;
    logic [11:0] avg_torque;
    logic [4:0]  cadence;
    logic        not_pedaling;
    logic [12:0] incline;
    logic [2:0]  scale;
    logic        out_vld;
    logic [11:0] target_curr;
    logic [11:0] raw_curr;
    logic        sat;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [11:0] raw;
        logic        sat;
        logic [11:0] tgt;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    desired_drive_ramp dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_vld       (in_vld),
        .avg_torque   (avg_torque),
        .cadence      (cadence),
        .not_pedaling (not_pedaling),
        .incline      (incline),
        .scale        (scale),
        .out_vld      (out_vld),
        .target_curr  (target_curr),
        .raw_curr     (raw_curr),
        .sat          (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every out_vld must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (out_vld) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_vld: got out_vld=1, expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("raw_curr", int'(raw_curr), int'(e.raw));
                chk("sat", int'(sat), int'(e.sat));
                chk("target_curr", int'(target_curr), int'(e.tgt));
                chk("latency", cyc, e.cyc);
            end
        end
    end

    task automatic drive(input logic [11:0] tq, input logic [4:0] cd, input logic [12:0] inc,
                         input logic [2:0] sc, input logic np);
        @(negedge clk);
        avg_torque   = tq;
        cadence      = cd;
        incline      = inc;
        scale        = sc;
        not_pedaling = np;
        in_vld       = 1'b1;
    endtask

    // Output appears in the cycle after the fourth edge following capture.
    task automatic send(input logic [11:0] tq, input logic [4:0] cd, input logic [12:0] inc,
                        input logic [2:0] sc, input logic np,
                        input int raw, input int sat_e, input int tgt);
        exp_t e;
        drive(tq, cd, inc, sc, np);
        e.raw = 12'(raw);
        e.sat = sat_e[0];
        e.tgt = 12'(tgt);
        e.cyc = cyc + 5;
        sb.push_back(e);
    endtask

    // Idle cycles with junk on the data inputs, which must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_vld       = 1'b0;
            avg_torque   = 12'($urandom);
            cadence      = 5'($urandom);
            incline      = 13'($urandom);
            scale        = 3'($urandom);
            not_pedaling = 1'($urandom);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle(1);
        while (sb.size() != 0 && n < 200) begin
            idle(1);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding, expected 0", sb.size());
            sb.delete();
        end
        idle(2);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    initial begin
        rst_n        = 1'b0;
        in_vld       = 1'b0;
        avg_torque   = '0;
        cadence      = '0;
        not_pedaling = 1'b0;
        incline      = '0;
        scale        = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_vld", int'(out_vld), 0);
        chk("rst_target", int'(target_curr), 0);
        chk("rst_raw", int'(raw_curr), 0);
        chk("rst_sat", int'(sat), 0);
        rst_n = 1'b1;
        idle(2);

        // Nominal ramp-up to 0xA1A: single isolated sample, then back-to-back.
        send(12'h800, 5'h10, 13'h0150, 3'd3, 1'b0, 'hA1A, 0, 'h040);
        idle(7);
        for (int k = 2; k <= 44; k++)
            send(12'h800, 5'h10, 13'h0150, 3'd3, 1'b0, 'hA1A, 0, imin(64 * k, 'hA1A));
        drain();

        // Saturation, then incline 0 giving 0xD66 exactly.
        send(12'h7E0, 5'h18, 13'h0080, 3'd7, 1'b0, 'hFFF, 1, 'hA1A + 64);
        send(12'h7E0, 5'h18, 13'h0080, 3'd7, 1'b0, 'hFFF, 1, 'hA1A + 128);
        for (int k = 1; k <= 13; k++)
            send(12'h7E0, 5'h18, 13'h0000, 3'd7, 1'b0, 'hD66, 0, imin('hA9A + 64 * k, 'hD66));
        drain();

        // Down-ramp from 0xD66 with torque below the offset.
        for (int k = 1; k <= 15; k++)
            send(12'h360, 5'h18, 13'h0000, 3'd7, 1'b0, 0, 0, imax('hD66 - 256 * k, 0));
        drain();

        // Negative incline.
        for (int k = 1; k <= 5; k++)
            send(12'h800, 5'h10, 13'h1F22, 3'd5, 1'b0, 'h11E, 0, imin(64 * k, 'h11E));
        send(12'h800, 5'h10, 13'h1EF0, 3'd5, 1'b0, 0, 0, 'h11E - 256);
        send(12'h800, 5'h10, 13'h1EF0, 3'd5, 1'b0, 0, 0, 0);
        drain();

        // Back up to 0xD66, then not_pedaling with saturating inputs.
        for (int k = 1; k <= 54; k++)
            send(12'h7E0, 5'h18, 13'h0000, 3'd7, 1'b0, 'hD66, 0, imin(64 * k, 'hD66));
        send(12'h7E0, 5'h18, 13'h0080, 3'd7, 1'b1, 0, 0, 0);
        idle(3);
        for (int k = 1; k <= 4; k++)
            send(12'h800, 5'h10, 13'h0150, 3'd3, 1'b0, 'hA1A, 0, 64 * k);
        drain();

        // Asynchronous reset with three samples in flight.
        drive(12'h800, 5'h10, 13'h0150, 3'd3, 1'b0);
        drive(12'h800, 5'h10, 13'h0150, 3'd3, 1'b0);
        drive(12'h800, 5'h10, 13'h0150, 3'd3, 1'b0);
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        in_vld = 1'b0;
        #1;
        chk("arst_out_vld", int'(out_vld), 0);
        chk("arst_target", int'(target_curr), 0);
        chk("arst_raw", int'(raw_curr), 0);
        chk("arst_sat", int'(sat), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(12);
        send(12'h800, 5'h10, 13'h0150, 3'd3, 1'b0, 'hA1A, 0, 'h040);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/desired_drive_ramp.md
# desired_drive_ramp

Parametrised, pipelined successor to the eBike desired-drive calculator. Converts averaged torque, cadence, incline and the rider assist scale into a motor target current, with registered valid handshaking and a slew-rate limiter on the output. Sits between the sensor-conditioning front end and the PID/motor-drive loop. It removes the single-cycle combinational multiply path and prevents current steps that jolt the rider.

## Interface
- TQ_W, 12, avg_torque width
- TORQUE_MIN, 12'h380, torque offset below which assist is zero
- INC_W, 13, signed incline width (≥10)
- CAD_W, 5, cadence width
- SCALE_W, 3, assist scale width
- CUR_W, 12, target current width
- SHIFT, 15, right shift applied to the full product
- RAMP_UP, 64, max target increase per valid sample
- RAMP_DN, 256, max target decrease per valid sample
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_vld  in  1  input sample valid, one-cycle qualifier
- avg_torque  in  TQ_W  unsigned averaged torque
- cadence  in  CAD_W  unsigned cadence
- not_pedaling  in  1  rider not pedaling
- incline  in  INC_W  signed incline
- scale  in  SCALE_W  unsigned assist level
- out_vld  out  1  one-cycle pulse, new target_curr/raw_curr/sat presented
- target_curr  out  CUR_W  slew-limited target current
- raw_curr  out  CUR_W  unlimited (pre-ramp) target of the same sample
- sat  out  1  raw product exceeded CUR_W range for the same sample

## Operation
- Stage 1 (factor), registered on in_vld:
  - torque_pos = avg_torque − TORQUE_MIN, or 0 if negative.
  - incline saturated to signed 10-bit (−512..511), then +256, then clipped to 0..511 (9-bit unsigned).
  - cad_f = (cadence > 1) ? cadence + 2^CAD_W : 0.
  - scale and not_pedaling are carried along.
- Stage 2 (multiply): p1 = torque_pos × incline_lim; p2 = cad_f × scale. Both products registered.
- Stage 3 (product/saturate): prod = p1 × p2, full width with no truncation.
  - If prod >> SHIFT > 2^CUR_W − 1: raw = all-ones, sat = 1.
  - Else raw = prod[SHIFT+CUR_W−1:SHIFT], sat = 0.
  - If not_pedaling: raw = 0, sat = 0.
- Stage 4 (ramp), updates only when a valid sample arrives:
  - not_pedaling: target = 0 immediately, ignoring RAMP_DN.
  - raw > target: target = min(raw, target + RAMP_UP).
  - raw < target: target = max(raw, target − RAMP_DN), never below 0.
  - raw == target: target holds.
- target_curr holds between valid samples. raw_curr and sat also hold their last values.
- Valid bit shifts through each stage every cycle. There is no backpressure and no stall; bubbles propagate unchanged.
- Back-to-back in_vld accepted every cycle; samples are never merged or dropped.

## Timing
- Latency: in_vld sampled at edge N gives out_vld high for exactly the cycle after edge N+4, with the corresponding outputs valid in that same cycle.
- Throughput: 1 sample/cycle.
- Reset (asynchronous, any time, including mid-pipeline):
  - All pipeline registers and valid bits clear to 0.
  - out_vld = 0, target_curr = 0, raw_curr = 0, sat = 0.
  - In-flight samples are discarded; no out_vld is produced for them after reset release.
- Ramp arithmetic is computed at width CUR_W+1 so target + RAMP_UP cannot wrap. Downward steps saturate at 0.
- Simultaneous not_pedaling and sat in one sample: not_pedaling wins, so raw = 0 and sat = 0.
- Inputs are sampled only on cycles with in_vld = 1. Changes on other cycles have no effect.

## Test plan
- Default params; avg_torque 12'h800, cadence 5'h10, incline 13'h0150, scale 3, not_pedaling 0; one in_vld pulse.
  - Expect out_vld exactly 4 cycles later, raw_curr = 12'hA1A, sat = 0, target_curr = 12'h040.
  - Repeat the sample until target_curr reaches 12'hA1A on the 41st sample and holds there.
- Saturation: avg_torque 12'h7E0, cadence 5'h18, incline 13'h0080, scale 7 → raw_curr = 12'hFFF, sat = 1, target_curr rises by 64 per sample.
  - Same sample with incline 13'h0000 → raw_curr = 12'hD66, sat = 0.
- Down-ramp: settle target at 12'hD66, then apply avg_torque 12'h360 → raw_curr 0.
  - target_curr steps 12'hC66, 12'hB66, …, reaching 0 on the 14th sample.
- Negative incline: incline 13'h1F22 with avg_torque 12'h800, cadence 5'h10, scale 5 → raw_curr = 12'h11E.
  - incline 13'h1EF0 → raw_curr = 0.
- not_pedaling = 1 with target at 12'hD66 → next out_vld shows target_curr = 0 and raw_curr = 0.
  - Then 4 consecutive in_vld cycles → 4 consecutive out_vld pulses, in order.
- Assert rst_n low with 3 samples in flight → all outputs 0 immediately and no out_vld after release.
  - Next sample ramps from 0.
